// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern controller: switch modes, FSM states and shift direction.
package led_pattern_pkg;

  localparam logic [1:0] MODE_ROT_L = 2'b00;
  localparam logic [1:0] MODE_ROT_R = 2'b01;
  localparam logic [1:0] MODE_PP    = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  localparam int NUM_STATES = 5;

  typedef enum logic [2:0] {
    ST_ROT_L = 3'd0,
    ST_ROT_R = 3'd1,
    ST_PP_L  = 3'd2,
    ST_PP_R  = 3'd3,
    ST_FLASH = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_color_route.sv
// Registered routing of the display value onto the red, blue and green LED buses.
module led_color_route #(
  parameter int LED_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_color,
  input  logic [LED_WIDTH-1:0] i_disp,
  output logic [LED_WIDTH-1:0] o_led,
  output logic [LED_WIDTH-1:0] o_led_b,
  output logic [LED_WIDTH-1:0] o_led_g
);

  // output register stage: blanked when disabled, colour bus chosen by i_color
  always_ff @(posedge clock) begin
    if (i_reset || !i_enable) begin
      o_led   <= '0;
      o_led_b <= '0;
      o_led_g <= '0;
    end else begin
      o_led   <= i_disp;
      o_led_b <= i_color ? i_disp : '0;
      o_led_g <= i_color ? '0 : i_disp;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern state machine advanced by the counter step strobe.
// Optional step counter output enabled by defining LED_STEP_CNT_EN.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int LED_WIDTH = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  input  logic                 i_color,
  output logic [LED_WIDTH-1:0] o_led,
  output logic [LED_WIDTH-1:0] o_led_b,
  output logic [LED_WIDTH-1:0] o_led_g
`ifdef LED_STEP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] o_step_count
`endif
);

  if (LED_WIDTH < 2 || CNT_WIDTH < 1) begin : g_bad_param
    $error("led_pattern_ctrl: LED_WIDTH must be >= 2 and CNT_WIDTH >= 1");
  end

  function automatic logic [LED_WIDTH-1:0] rot_left(input logic [LED_WIDTH-1:0] p);
    return {p[LED_WIDTH-2:0], p[LED_WIDTH-1]};
  endfunction

  function automatic logic [LED_WIDTH-1:0] rot_right(input logic [LED_WIDTH-1:0] p);
    return {p[0], p[LED_WIDTH-1:1]};
  endfunction

  state_t               state_p0, state_n;
  logic [LED_WIDTH-1:0] pattern_p0, pattern_n;
  logic                 dir_p0, dir_n, pp_dir;
  logic                 flash_on_p0, flash_n;
  logic [LED_WIDTH-1:0] disp_n;
  logic                 step;

  assign step = i_valid & i_enable;

  // Next state, pattern and display are computed in the same step from the new mode
  always_comb begin
    state_n   = state_p0;
    pattern_n = pattern_p0;
    dir_n     = dir_p0;
    flash_n   = flash_on_p0;
    pp_dir    = DIR_LEFT;
    if (step) begin
      case (i_mode)
        MODE_ROT_L: begin
          state_n   = ST_ROT_L;
          pattern_n = rot_left(pattern_p0);
        end
        MODE_ROT_R: begin
          state_n   = ST_ROT_R;
          pattern_n = rot_right(pattern_p0);
        end
        MODE_PP: begin
          pp_dir = (state_p0 == ST_PP_L || state_p0 == ST_PP_R) ? dir_p0 : DIR_LEFT;
          // A lit end bit can only be left inward; keeps the pattern one-hot
          if (pp_dir == DIR_LEFT && pattern_p0[LED_WIDTH-1])
            pp_dir = DIR_RIGHT;
          else if (pp_dir == DIR_RIGHT && pattern_p0[0])
            pp_dir = DIR_LEFT;
          pattern_n = (pp_dir == DIR_LEFT) ? (pattern_p0 << 1) : (pattern_p0 >> 1);
          dir_n = pp_dir;
          if (pp_dir == DIR_LEFT && pattern_n[LED_WIDTH-1])
            dir_n = DIR_RIGHT;
          else if (pp_dir == DIR_RIGHT && pattern_n[0])
            dir_n = DIR_LEFT;
          state_n = (dir_n == DIR_LEFT) ? ST_PP_L : ST_PP_R;
        end
        MODE_FLASH: begin
          state_n = ST_FLASH;
          flash_n = (state_p0 == ST_FLASH) ? ~flash_on_p0 : 1'b1;
        end
        default: ;
      endcase
    end
    if (state_n == ST_FLASH)
      disp_n = flash_n ? '1 : '0;
    else
      disp_n = pattern_n;
  end

  // pattern state register stage
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_p0    <= ST_ROT_L;
      pattern_p0  <= {{(LED_WIDTH-1){1'b0}}, 1'b1};
      dir_p0      <= DIR_LEFT;
      flash_on_p0 <= 1'b1;
    end else begin
      state_p0    <= state_n;
      pattern_p0  <= pattern_n;
      dir_p0      <= dir_n;
      flash_on_p0 <= flash_n;
    end
  end

  led_color_route #(
    .LED_WIDTH (LED_WIDTH)
  ) u_color_route (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_color  (i_color),
    .i_disp   (disp_n),
    .o_led    (o_led),
    .o_led_b  (o_led_b),
    .o_led_g  (o_led_g)
  );

`ifdef LED_STEP_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_p0;

  always_ff @(posedge clock) begin
    if (i_reset)
      cnt_p0 <= '0;
    else if (step)
      cnt_p0 <= cnt_p0 + 1'b1;
  end

  assign o_step_count = cnt_p0;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl at LED_WIDTH=4.
module tb_led_pattern_ctrl;

  localparam int W = 4;
  localparam int CW = 8;

  logic         clock = 1'b0;
  logic         i_reset;
  logic         i_valid;
  logic         i_enable;
  logic [1:0]   i_mode;
  logic         i_color;
  logic [W-1:0] o_led, o_led_b, o_led_g;
`ifdef LED_STEP_CNT_EN
  logic [CW-1:0] o_step_count;
`endif

  int checks = 0;
  int failures = 0;

  led_pattern_ctrl #(.LED_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .i_color  (i_color),
    .o_led    (o_led),
    .o_led_b  (o_led_b),
    .o_led_g  (o_led_g)
`ifdef LED_STEP_CNT_EN
    ,
    .o_step_count (o_step_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_valid = 0; i_enable = 1; i_mode = 2'b00; i_color = 0;
    do_reset();
    checks++;
    if ({o_led, o_led_b, o_led_g} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {o_led, o_led_b, o_led_g});
    end
`ifdef LED_STEP_CNT_EN
    checks++;
    if (o_step_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", o_step_count);
    end
`endif
    tick();
    checks++;
    if ({o_led, o_led_b, o_led_g} !== {4'b0001, 4'b0000, 4'b0001}) begin
      failures++;
      $display("FAIL reset_release got=%b_%b_%b exp=0001_0000_0001", o_led, o_led_b, o_led_g);
    end
  endtask

  task automatic test_rot_left();
    logic [W-1:0] exp_t [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    i_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      pulse();
      checks++;
      if ({o_led, o_led_b, o_led_g} !== {exp_t[i], 4'b0000, exp_t[i]}) begin
        failures++;
        $display("FAIL rot_left[%0d] got=%b_%b_%b exp=%b_0000_%b", i, o_led, o_led_b, o_led_g, exp_t[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_ping_pong();
    logic [W-1:0] exp_t [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010, 4'b0100};
    do_reset();
    i_mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      pulse();
      checks++;
      if (o_led !== exp_t[i] || o_led_g !== exp_t[i]) begin
        failures++;
        $display("FAIL ping_pong[%0d] got=%b/%b exp=%b", i, o_led, o_led_g, exp_t[i]);
      end
    end
  endtask

  task automatic test_flash();
    logic [W-1:0] exp_t [3] = '{4'b1111, 4'b0000, 4'b1111};
    i_mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      pulse();
      checks++;
      if (o_led !== exp_t[i] || o_led_g !== exp_t[i]) begin
        failures++;
        $display("FAIL flash[%0d] got=%b/%b exp=%b", i, o_led, o_led_g, exp_t[i]);
      end
    end
    i_mode = 2'b01;
    pulse();
    checks++;
    if (o_led !== 4'b0010) begin
      failures++;
      $display("FAIL flash_exit got=%b exp=0010", o_led);
    end
  endtask

  task automatic test_enable();
    i_mode = 2'b00;
    pulse();
    pulse();
    checks++;
    if (o_led !== 4'b1000) begin
      failures++;
      $display("FAIL enable_setup got=%b exp=1000", o_led);
    end
    i_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse();
      checks++;
      if ({o_led, o_led_b, o_led_g} !== 12'h000) begin
        failures++;
        $display("FAIL disabled[%0d] got=%h exp=000", i, {o_led, o_led_b, o_led_g});
      end
    end
    i_enable = 1'b1;
    tick();
    checks++;
    if (o_led !== 4'b1000 || o_led_g !== 4'b1000) begin
      failures++;
      $display("FAIL reenable got=%b/%b exp=1000", o_led, o_led_g);
    end
    pulse();
    checks++;
    if (o_led !== 4'b0001) begin
      failures++;
      $display("FAIL reenable_step got=%b exp=0001", o_led);
    end
  endtask

  task automatic test_color();
    i_color = 1'b1;
    tick();
    checks++;
    if ({o_led, o_led_b, o_led_g} !== {4'b0001, 4'b0001, 4'b0000}) begin
      failures++;
      $display("FAIL color_blue got=%b_%b_%b exp=0001_0001_0000", o_led, o_led_b, o_led_g);
    end
    i_color = 1'b0;
    tick();
    checks++;
    if ({o_led, o_led_b, o_led_g} !== {4'b0001, 4'b0000, 4'b0001}) begin
      failures++;
      $display("FAIL color_green got=%b_%b_%b exp=0001_0000_0001", o_led, o_led_b, o_led_g);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_t [3] = '{4'b0010, 4'b0100, 4'b1000};
    i_mode = 2'b00;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_led !== exp_t[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, o_led, exp_t[i]);
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_mode = 2'b10;
    for (int i = 0; i < 4; i++) pulse();
    checks++;
    if (o_led !== 4'b0100) begin
      failures++;
      $display("FAIL pp_right_setup got=%b exp=0100", o_led);
    end
    i_reset = 1'b1;
    i_valid = 1'b1;
    tick();
    i_reset = 1'b0;
    i_valid = 1'b0;
    checks++;
    if ({o_led, o_led_b, o_led_g} !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=000", {o_led, o_led_b, o_led_g});
    end
    tick();
    checks++;
    if (o_led !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset_release got=%b exp=0001", o_led);
    end
    pulse();
    checks++;
    if (o_led !== 4'b0010) begin
      failures++;
      $display("FAIL mid_reset_pp1 got=%b exp=0010", o_led);
    end
    pulse();
    checks++;
    if (o_led !== 4'b0100) begin
      failures++;
      $display("FAIL mid_reset_pp2 got=%b exp=0100", o_led);
    end
  endtask

`ifdef LED_STEP_CNT_EN
  task automatic test_step_count();
    do_reset();
    i_mode = 2'b00;
    i_valid = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    checks++;
    if (o_step_count !== 8'd255) begin
      failures++;
      $display("FAIL count_255 got=%0d exp=255", o_step_count);
    end
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_step_count !== 8'd0 || o_led !== 4'b0001) begin
      failures++;
      $display("FAIL count_wrap got=%0d/%b exp=0/0001", o_step_count, o_led);
    end
    i_enable = 1'b0;
    pulse();
    i_enable = 1'b1;
    checks++;
    if (o_step_count !== 8'd0) begin
      failures++;
      $display("FAIL count_frozen got=%0d exp=0", o_step_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rot_left();
    test_ping_pong();
    test_flash();
    test_enable();
    test_color();
    test_back_to_back();
    test_reset_mid();
`ifdef LED_STEP_CNT_EN
    test_step_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
